// File: rtl/trainer_pkg.sv
// Shared types and helpers for the trainer sequencer.
//   state_t : sequencer states (idle, per-sample handshake steps, done)
//   sat_sub : signed a - b, saturated to an r-bit two's complement range
package trainer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARG,
    RES,
    ERR,
    PRP,
    CHK,
    DONE
  } state_t;

  // Operands arrive sign-extended to 33 bits (r <= 31), so the subtraction
  // itself can never overflow; only the clamp to r bits matters.
  function automatic logic [32:0] sat_sub(input logic [32:0] a,
                                          input logic [32:0] b,
                                          input int unsigned r);
    logic signed [32:0] diff;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    diff = $signed(a) - $signed(b);
    hi   = (33'sd1 <<< (r - 1)) - 33'sd1;
    lo   = -(33'sd1 <<< (r - 1));
    if (diff > hi) begin
      sat_sub = hi;
    end else if (diff < lo) begin
      sat_sub = lo;
    end else begin
      sat_sub = diff;
    end
  endfunction

endpackage

// File: rtl/trainer_memory.sv
// Sample table: DEPTH x DW register file.
//   clock           : write clock
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_addr/rd_data : combinational read port
// Contents are deliberately not reset; validity is tracked by the owner.
module trainer_memory
  import trainer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/trainer.sv
// Training/evaluation sequencer for one product neuron.
//   clock, reset           : clock, asynchronous active-high reset
//   load_*                 : host writes (argument, target) samples into the table
//   start/busy/done        : run control; fail_count valid from done
//   train                  : 1 during training passes
//   argument_* (out)       : sample arguments to the product
//   result_*   (in)        : product result
//   error_*    (out)       : saturated target - result, training passes only
//   propagate_* (in)       : drained and discarded
// Every output is a flop; the next-state logic runs in one always_comb.
module trainer
  import trainer_pkg::*;
#(
  parameter int N       = 2,
  parameter int W       = 8,
  parameter int R       = 16,
  parameter int SAMPLES = 4,
  parameter int EPOCHS  = 25,
  parameter int TOL     = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [N*W-1:0]                   load_argument,
  input  logic [R-1:0]                     load_target,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(SAMPLES+1)-1:0]     fail_count,
  output logic                             train,
  output logic                             argument_valid,
  input  logic                             argument_ready,
  output logic [N*W-1:0]                   argument_data,
  input  logic                             result_valid,
  output logic                             result_ready,
  input  logic [R-1:0]                     result_data,
  output logic                             error_valid,
  input  logic                             error_ready,
  output logic [R-1:0]                     error_data,
  input  logic                             propagate_valid,
  output logic                             propagate_ready,
  input  logic [N*R-1:0]                   propagate_data
);

  localparam int CW = $clog2(SAMPLES + 1);
  localparam int AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int EW = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;
  localparam int DW = N * W + R;

  localparam logic [CW-1:0] CNT_ONE    = 1;
  localparam logic [CW-1:0] CNT_FULL   = CW'(SAMPLES);
  localparam logic [EW-1:0] EPOCH_ONE  = 1;
  localparam logic [EW-1:0] EPOCH_LAST = EW'(EPOCHS - 1);
  localparam logic [R-1:0]  R_MAX      = {1'b0, {(R-1){1'b1}}};
  localparam logic [R-1:0]  R_MIN      = {1'b1, {(R-1){1'b0}}};
  localparam logic [R-1:0]  TOL_R      = R'(TOL);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [EW-1:0] epoch_q, epoch_d;
  logic [CW-1:0] fail_q, fail_d;
  logic [R-1:0]  err_q, err_d;
  logic          load_ready_q, load_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          train_q, train_d;
  logic          arg_valid_q, arg_valid_d;
  logic          res_ready_q, res_ready_d;
  logic          err_valid_q, err_valid_d;
  logic          prp_ready_q, prp_ready_d;

  logic          load_xfer;
  logic [CW-1:0] count_after;
  logic [DW-1:0] entry;
  logic [R-1:0]  entry_target;
  logic [32:0]   sat_full;
  logic [R-1:0]  err_new;
  logic [R-1:0]  err_mag;
  logic          advance;
  logic          unused_bits;

  assign load_xfer   = load_valid && load_ready_q;
  assign count_after = load_xfer ? count_q + CNT_ONE : count_q;

  trainer_memory #(
    .DEPTH (SAMPLES),
    .DW    (DW),
    .AW    (AW)
  ) u_memory (
    .clock   (clock),
    .wr_en   (load_xfer),
    .wr_addr (count_q[AW-1:0]),
    .wr_data ({load_argument, load_target}),
    .rd_addr (idx_q[AW-1:0]),
    .rd_data (entry)
  );

  assign entry_target = entry[R-1:0];

  assign sat_full = sat_sub({{(33-R){entry_target[R-1]}}, entry_target},
                            {{(33-R){result_data[R-1]}}, result_data},
                            R);
  assign err_new  = sat_full[R-1:0];

  // Most negative error has no positive twin; treat it as the largest magnitude.
  always_comb begin
    if (err_q == R_MIN) begin
      err_mag = R_MAX;
    end else if (err_q[R-1]) begin
      err_mag = -err_q;
    end else begin
      err_mag = err_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_after;
    idx_d        = idx_q;
    epoch_d      = epoch_q;
    fail_d       = fail_q;
    err_d        = err_q;
    load_ready_d = load_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    train_d      = train_q;
    arg_valid_d  = arg_valid_q;
    res_ready_d  = res_ready_q;
    err_valid_d  = err_valid_q;
    prp_ready_d  = prp_ready_q;
    advance      = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready_d = (count_after != CNT_FULL);
        // A load in the same cycle as start is already counted in count_after.
        if (start) begin
          fail_d       = '0;
          busy_d       = 1'b1;
          load_ready_d = 1'b0;
          idx_d        = '0;
          epoch_d      = '0;
          if (count_after == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ARG;
            train_d     = 1'b1;
            arg_valid_d = 1'b1;
          end
        end
      end
      ARG: begin
        if (argument_ready) begin
          arg_valid_d = 1'b0;
          res_ready_d = 1'b1;
          state_d     = RES;
        end
      end
      RES: begin
        if (result_valid) begin
          res_ready_d = 1'b0;
          err_d       = err_new;
          if (train_q) begin
            err_valid_d = 1'b1;
            state_d     = ERR;
          end else begin
            state_d = CHK;
          end
        end
      end
      ERR: begin
        if (error_ready) begin
          err_valid_d = 1'b0;
          prp_ready_d = 1'b1;
          state_d     = PRP;
        end
      end
      PRP: begin
        if (propagate_valid) begin
          prp_ready_d = 1'b0;
          advance     = 1'b1;
        end
      end
      CHK: begin
        if (err_mag >= TOL_R) begin
          fail_d = fail_q + CNT_ONE;
        end
        advance = 1'b1;
      end
      DONE: begin
        busy_d       = 1'b0;
        state_d      = IDLE;
        load_ready_d = (count_q != CNT_FULL);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of a sample: next sample, next epoch, switch to the evaluation
    // pass (train drops together with the new argument_valid), or finish.
    if (advance) begin
      if (idx_q + CNT_ONE != count_q) begin
        idx_d       = idx_q + CNT_ONE;
        state_d     = ARG;
        arg_valid_d = 1'b1;
      end else if (train_q) begin
        idx_d       = '0;
        state_d     = ARG;
        arg_valid_d = 1'b1;
        if (epoch_q == EPOCH_LAST) begin
          train_d = 1'b0;
        end else begin
          epoch_d = epoch_q + EPOCH_ONE;
        end
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      epoch_q      <= '0;
      fail_q       <= '0;
      err_q        <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      train_q      <= 1'b0;
      arg_valid_q  <= 1'b0;
      res_ready_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      prp_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      epoch_q      <= epoch_d;
      fail_q       <= fail_d;
      err_q        <= err_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      train_q      <= train_d;
      arg_valid_q  <= arg_valid_d;
      res_ready_q  <= res_ready_d;
      err_valid_q  <= err_valid_d;
      prp_ready_q  <= prp_ready_d;
    end
  end

  assign load_ready      = load_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fail_count      = fail_q;
  assign train           = train_q;
  assign argument_valid  = arg_valid_q;
  assign argument_data   = entry[DW-1:R];
  assign result_ready    = res_ready_q;
  assign error_valid     = err_valid_q;
  assign error_data      = err_q;
  assign propagate_ready = prp_ready_q;

  // Propagate payload is discarded; upper saturation bits are redundant.
  assign unused_bits = ^{propagate_data, sat_full[32:R]};

endmodule

// File: tb/tb_trainer.sv
module tb_trainer;
  localparam int N = 2, W = 8, R = 16, SAMPLES = 4, EPOCHS = 25, TOL = 5;
  localparam int CW = $clog2(SAMPLES + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load_valid = 1'b0, load_ready;
  logic [N*W-1:0] load_argument = '0;
  logic [R-1:0] load_target = '0;
  logic start = 1'b0, busy, done, train;
  logic [CW-1:0] fail_count;
  logic argument_valid, argument_ready = 1'b0;
  logic [N*W-1:0] argument_data;
  logic result_valid = 1'b0, result_ready;
  logic [R-1:0] result_data = '0;
  logic error_valid, error_ready = 1'b0;
  logic [R-1:0] error_data;
  logic propagate_valid = 1'b0, propagate_ready;
  logic [N*R-1:0] propagate_data = '0;

  always #5 clock = ~clock;

  trainer #(.N(N), .W(W), .R(R), .SAMPLES(SAMPLES), .EPOCHS(EPOCHS), .TOL(TOL)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_argument(load_argument), .load_target(load_target),
    .start(start), .busy(busy), .done(done), .fail_count(fail_count), .train(train),
    .argument_valid(argument_valid), .argument_ready(argument_ready), .argument_data(argument_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .error_valid(error_valid), .error_ready(error_ready), .error_data(error_data),
    .propagate_valid(propagate_valid), .propagate_ready(propagate_ready),
    .propagate_data(propagate_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [N*W-1:0] s_arg [SAMPLES];
  logic [R-1:0]   s_tgt [SAMPLES];
  int             n_model = 0;
  logic [R-1:0]   fixed_res [SAMPLES];
  logic [R-1:0]   first_err [SAMPLES];
  bit stall_en = 0, fixed_mode = 0, hold_arg = 0;
  int a_cnt, r_cnt, e_cnt, p_cnt, done_cnt, exp_fail, stab_bad;
  int exp_err_q[$];
  bit train_seen;
  logic [CW-1:0] fc_at_done;

  // product stub state
  bit res_pending = 0, res_drop = 0, prp_pending = 0, prp_drop = 0;
  logic [R-1:0] next_res = '0;
  bit arg_wait = 0, err_wait = 0, train_hold = 0;
  logic [N*W-1:0] arg_hold = '0;
  logic [R-1:0] err_hold = '0;

  function automatic int clamp_err(input logic [R-1:0] t, input logic [R-1:0] r);
    int d, hi, lo;
    d  = int'($signed(t)) - int'($signed(r));
    hi = (1 << (R - 1)) - 1;
    lo = -(1 << (R - 1));
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

  function automatic logic [R-1:0] pick_result(input logic [R-1:0] t);
    logic [R-1:0] off;
    off = R'($urandom_range(0, 12));
    case ($urandom_range(0, 4))
      0, 1: return t + off - R'(6);
      2: return {1'b1, {(R-1){1'b0}}};
      3: return {1'b0, {(R-1){1'b1}}};
      default: return R'($urandom);
    endcase
  endfunction

  task automatic clear_model();
    a_cnt = 0; r_cnt = 0; e_cnt = 0; p_cnt = 0; done_cnt = 0;
    exp_fail = 0; stab_bad = 0; train_seen = 0; fc_at_done = '0;
    exp_err_q.delete();
  endtask

  // Product stub plus monitor; runs once per falling edge. Inputs set here hold
  // across the next rising edge, so a transfer is predicted from valid&&ready now.
  task automatic responder_step();
    int idx, pass, e;
    if (reset) begin
      argument_ready = 0; result_valid = 0; error_ready = 0; propagate_valid = 0;
      res_pending = 0; res_drop = 0; prp_pending = 0; prp_drop = 0;
      arg_wait = 0; err_wait = 0;
      return;
    end
    if (arg_wait && !(argument_valid && argument_data == arg_hold && train == train_hold)) stab_bad++;
    if (err_wait && !(error_valid && error_data == err_hold)) stab_bad++;
    if (train) train_seen = 1;
    if (done) begin done_cnt++; fc_at_done = fail_count; end

    if (res_drop) begin result_valid = 0; res_drop = 0; end
    if (prp_drop) begin propagate_valid = 0; prp_drop = 0; end
    argument_ready = !hold_arg && (!stall_en || $urandom_range(0, 2) != 0);
    error_ready    = !stall_en || $urandom_range(0, 2) != 0;
    if (res_pending && !result_valid && (!stall_en || $urandom_range(0, 2) != 0)) begin
      result_valid = 1; result_data = next_res;
    end
    if (prp_pending && !propagate_valid && (!stall_en || $urandom_range(0, 2) != 0)) begin
      propagate_valid = 1; propagate_data = {$urandom, $urandom};
    end

    if (argument_valid && argument_ready) begin
      idx  = (n_model > 0) ? a_cnt % n_model : 0;
      pass = (n_model > 0) ? a_cnt / n_model : 0;
      chk("argument_data", argument_data, s_arg[idx]);
      chk("train_level", train, pass < EPOCHS);
      a_cnt++;
      res_pending = 1;
      next_res = fixed_mode ? fixed_res[idx] : pick_result(s_tgt[idx]);
    end
    if (result_valid && result_ready) begin
      idx  = (n_model > 0) ? r_cnt % n_model : 0;
      pass = (n_model > 0) ? r_cnt / n_model : 0;
      e = clamp_err(s_tgt[idx], result_data);
      if (pass < EPOCHS) begin
        exp_err_q.push_back(e);
        if (pass == 0) first_err[idx] = e[R-1:0];
      end else if ((e < 0 ? -e : e) >= TOL) begin
        exp_fail++;
      end
      r_cnt++; res_pending = 0; res_drop = 1;
    end
    if (error_valid && error_ready) begin
      if (exp_err_q.size() == 0) begin
        chk("error_unexpected", 1, 0);
      end else begin
        e = exp_err_q.pop_front();
        chk("error_data", error_data, e[R-1:0]);
      end
      e_cnt++; prp_pending = 1;
    end
    if (propagate_valid && propagate_ready) begin
      p_cnt++; prp_pending = 0; prp_drop = 1;
    end
    arg_wait = argument_valid && !argument_ready;
    arg_hold = argument_data; train_hold = train;
    err_wait = error_valid && !error_ready;
    err_hold = error_data;
  endtask

  initial forever begin
    @(negedge clock);
    responder_step();
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic reset_all();
    @(negedge clock);
    reset = 1; start = 0; load_valid = 0; hold_arg = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 0; n_model = 0;
  endtask

  task automatic load_one(input logic [N*W-1:0] a, input logic [R-1:0] t);
    @(negedge clock);
    load_valid = 1; load_argument = a; load_target = t;
    chk("load_ready", load_ready, n_model < SAMPLES);
    if (n_model < SAMPLES) begin s_arg[n_model] = a; s_tgt[n_model] = t; n_model++; end
    @(negedge clock);
    load_valid = 0;
    $display("load arg=%h target=%h table=%0d", a, t, n_model);
  endtask

  task automatic do_run(input string name, input bit stall, input bit fixed,
                        input bit with_load, input bit poke);
    int cyc;
    logic [N*W-1:0] la;
    logic [R-1:0] lt;
    clear_model();
    stall_en = stall; fixed_mode = fixed;
    @(negedge clock);
    start = 1;
    if (with_load) begin
      la = N*W'($urandom); lt = R'($urandom);
      load_valid = 1; load_argument = la; load_target = lt;
      chk({name, " load_ready"}, load_ready, n_model < SAMPLES);
      if (n_model < SAMPLES) begin s_arg[n_model] = la; s_tgt[n_model] = lt; n_model++; end
    end
    @(negedge clock);
    start = 0; load_valid = 0;
    chk({name, " busy_after_start"}, busy, 1);
    if (n_model == 0) chk({name, " done_next_cycle"}, done, 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (poke && cyc == 40) begin
        start = 1; load_valid = 1; load_argument = N*W'($urandom); load_target = R'($urandom);
        chk({name, " load_ready_busy"}, load_ready, 0);
      end
      if (poke && cyc == 41) begin start = 0; load_valid = 0; end
    end
    @(negedge clock);
    @(negedge clock);
    chk({name, " done_pulses"}, done_cnt, 1);
    chk({name, " busy_end"}, busy, 0);
    chk({name, " done_end"}, done, 0);
    chk({name, " load_ready_end"}, load_ready, n_model < SAMPLES);
    chk({name, " arg_xfers"}, a_cnt, n_model * (EPOCHS + 1));
    chk({name, " res_xfers"}, r_cnt, n_model * (EPOCHS + 1));
    chk({name, " err_xfers"}, e_cnt, n_model * EPOCHS);
    chk({name, " prp_xfers"}, p_cnt, n_model * EPOCHS);
    chk({name, " err_left"}, exp_err_q.size(), 0);
    chk({name, " stable"}, stab_bad, 0);
    chk({name, " fail_at_done"}, fc_at_done, exp_fail);
    chk({name, " fail_held"}, fail_count, exp_fail);
    $display("run %s samples=%0d args=%0d errs=%0d fail_count=%0d", name, n_model, a_cnt, e_cnt, fail_count);
  endtask

  typedef struct {
    logic [R-1:0] tgt;
    logic [R-1:0] res;
    logic [R-1:0] exp_err;
    int           exp_fail;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int grp_fail;
    vecs[0] = '{16'h7fff, 16'h8000, 16'h7fff, 1};
    vecs[1] = '{16'h8000, 16'h7fff, 16'h8000, 1};
    vecs[2] = '{16'h0005, 16'h0000, 16'h0005, 1};
    vecs[3] = '{16'h0004, 16'h0000, 16'h0004, 0};
    vecs[4] = '{16'h0000, 16'h0004, 16'hfffc, 0};
    vecs[5] = '{16'h0000, 16'h0005, 16'hfffb, 1};
    vecs[6] = '{16'h0010, 16'h0010, 16'h0000, 0};
    vecs[7] = '{16'hff00, 16'h0100, 16'hfe00, 1};

    // reset state
    repeat (2) @(negedge clock);
    chk("rst load_ready", load_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst fail_count", fail_count, 0);
    chk("rst train", train, 0);
    chk("rst argument_valid", argument_valid, 0);
    chk("rst result_ready", result_ready, 0);
    chk("rst error_valid", error_valid, 0);
    chk("rst propagate_ready", propagate_ready, 0);
    reset = 0;

    // table-driven saturation / tolerance vectors, four samples per run
    for (int g = 0; g < 2; g++) begin
      reset_all();
      grp_fail = 0;
      for (int i = 0; i < SAMPLES; i++) begin
        load_one(N*W'($urandom), vecs[g*4+i].tgt);
        fixed_res[i] = vecs[g*4+i].res;
        grp_fail += vecs[g*4+i].exp_fail;
      end
      do_run($sformatf("table%0d", g), 0, 1, 0, 0);
      for (int i = 0; i < SAMPLES; i++)
        chk($sformatf("table%0d err%0d", g, i), first_err[i], vecs[g*4+i].exp_err);
      chk($sformatf("table%0d fail_count", g), fail_count, grp_fail);
    end

    // empty table: done on the next cycle, train never raised
    reset_all();
    do_run("empty", 0, 0, 0, 0);
    chk("empty train_seen", train_seen, 0);

    // load and start in the same cycle: one-sample run
    do_run("load_and_start", 1, 0, 1, 0);

    // full table, ignored 5th load, stalls, start pulsed while busy
    reset_all();
    load_one(16'h0000, 16'hff00);
    load_one(16'h00ff, 16'h007f);
    load_one(16'hff00, 16'hff00);
    load_one(16'hffff, 16'h007f);
    load_one(16'h1234, 16'h0001);
    chk("full table size", n_model, SAMPLES);
    do_run("stall_poke", 1, 0, 0, 1);
    do_run("rerun", 1, 0, 0, 0);

    // reset while argument_valid is held
    reset_all();
    load_one(16'h0102, 16'h0003);
    load_one(16'h0304, 16'h0007);
    clear_model();
    hold_arg = 1;
    @(negedge clock); start = 1;
    @(negedge clock); start = 0;
    for (int c = 0; c < 20 && !argument_valid; c++) @(negedge clock);
    chk("midarg argument_valid_before", argument_valid, 1);
    #2 reset = 1;
    #1;
    chk("midarg argument_valid", argument_valid, 0);
    chk("midarg busy", busy, 0);
    chk("midarg load_ready", load_ready, 1);
    chk("midarg fail_count", fail_count, 0);
    chk("midarg train", train, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 0; hold_arg = 0; n_model = 0;
    do_run("after_reset_empty", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
